regfile_mp: RTL

Parametrised multi-read-port architectural register file for the pipelined MIPS core. It sits in the decode stage and provides:
- `NUM_RD` registered read ports with same-cycle write-through bypass
- a general writeback port and a dedicated link-register port for jal
- HI/LO holding registers and always-visible v0/a0 taps for syscall handling
- a sequenced synchronous-reset clear, so every register, including the stack pointer seed, is initialised in hardware rather than by simulation-only initialisation

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_rdport.sv | 44 ++++
 rtl/regfile_mp.sv | 110 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and FSM state type for the MIPS register file
package regfile_pkg;

    localparam int REG_ZERO = 0;
    localparam int REG_V0   = 2;
    localparam int REG_A0   = 4;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

    localparam logic [31:0] SP_INIT_DEFAULT = 32'h7FFF_FFFC;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one registered read port with write-through bypass
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter int LINK_REG = REG_RA
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [AW-1:0]    ra,
    input  logic [WIDTH-1:0] arr_data,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             link_en,
    input  logic [WIDTH-1:0] link_data,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] rdata_next;

    // Link beats writeback: jal is the younger instruction in the same cycle.
    always_comb begin
        rdata_next = arr_data;
        if (ra == AW'(REG_ZERO)) begin
            rdata_next = '0;
        end else if (link_en && ra == AW'(LINK_REG)) begin
            rdata_next = link_data;
        end else if (wb_en && ra == wb_addr) begin
            rdata_next = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rdata <= '0;
        end else begin
            rdata <= rdata_next;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with hardware clear sequence, HI/LO and syscall taps
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int              WIDTH    = 32,
    parameter int              DEPTH    = 32,
    parameter int              NUM_RD   = 2,
    parameter int              SP_REG   = REG_SP,
    parameter logic [WIDTH-1:0] SP_INIT = WIDTH'(SP_INIT_DEFAULT),
    parameter int              LINK_REG = REG_RA,
    parameter int              V0_REG   = REG_V0,
    parameter int              A0_REG   = REG_A0,
    localparam int             AW       = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_RD*AW-1:0]    ra,
    output logic [NUM_RD*WIDTH-1:0] rdata,
    input  logic                    we,
    input  logic [AW-1:0]           wa,
    input  logic [WIDTH-1:0]        wd,
    input  logic                    link_we,
    input  logic [WIDTH-1:0]        link_wd,
    input  logic                    hilo_we,
    input  logic [WIDTH-1:0]        hi_wd,
    input  logic [WIDTH-1:0]        lo_wd,
    output logic [WIDTH-1:0]        hi,
    output logic [WIDTH-1:0]        lo,
    output logic [WIDTH-1:0]        v0,
    output logic [WIDTH-1:0]        a0,
    output logic                    busy
);

    logic [WIDTH-1:0] regs [DEPTH];
    state_t           state;
    state_t           state_next;
    logic [AW-1:0]    cnt;
    logic             wb_en;
    logic             link_en;

    assign busy    = (state == CLEAR);
    assign wb_en   = we && !busy && (wa != AW'(REG_ZERO));
    assign link_en = link_we && !busy;

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (cnt == AW'(DEPTH - 1)) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (busy) cnt <= cnt + AW'(1);
        end
    end

    // The array itself has no reset term; the CLEAR walk initialises every entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy) begin
                regs[cnt] <= (cnt == AW'(SP_REG)) ? SP_INIT : '0;
            end else begin
                if (wb_en)   regs[wa] <= wd;
                if (link_en) regs[AW'(LINK_REG)] <= link_wd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (hilo_we && !busy) begin
            hi <= hi_wd;
            lo <= lo_wd;
        end
    end

    // Entries at or above cnt have not been cleared yet, so mask their stale contents.
    assign v0 = (busy && cnt <= AW'(V0_REG)) ? '0 : regs[AW'(V0_REG)];
    assign a0 = (busy && cnt <= AW'(A0_REG)) ? '0 : regs[AW'(A0_REG)];

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_rdport #(
            .WIDTH    (WIDTH),
            .AW       (AW),
            .LINK_REG (LINK_REG)
        ) u_rdport (
            .clk       (clk),
            .rst       (rst),
            .clear     (busy),
            .ra        (ra[p*AW +: AW]),
            .arr_data  (regs[ra[p*AW +: AW]]),
            .wb_en     (wb_en),
            .wb_addr   (wa),
            .wb_data   (wd),
            .link_en   (link_en),
            .link_data (link_wd),
            .rdata     (rdata[p*WIDTH +: WIDTH])
        );
    end

endmodule
